// File: rtl/cve2_sleep_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cve2_pkg : shared types and constants for the WFI sleep controller.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package cve2_pkg;

    localparam int unsigned c_wake_cnt_w    = 4;
    localparam int unsigned c_timeout_cnt_w = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } sleep_ctrl_state_e;

    // Events that end a WFI: pending enabled interrupt or external debug request.
    function automatic logic wake_event(input logic irq_pending, input logic debug_req);
        return irq_pending | debug_req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cve2_sleep_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cve2_sleep_ctrl_if : core-side control and sleep-unit signals of the     |
// | WFI sleep controller.  Revision : 1.0                                    |
// +--------------------------------------------------------------------------+
interface cve2_sleep_ctrl_if;

    logic fetch_enable_i;
    logic wfi_i;
    logic irq_pending_i;
    logic debug_req_i;
    logic debug_mode_i;
    logic if_busy_i;
    logic lsu_busy_i;

    logic ctrl_busy_o;
    logic wake_from_sleep_o;
    logic halt_if_o;
    logic wfi_done_o;
    logic timeout_o;

    modport master (
        output fetch_enable_i,
        output wfi_i,
        output irq_pending_i,
        output debug_req_i,
        output debug_mode_i,
        output if_busy_i,
        output lsu_busy_i,
        input  ctrl_busy_o,
        input  wake_from_sleep_o,
        input  halt_if_o,
        input  wfi_done_o,
        input  timeout_o
    );

    modport slave (
        input  fetch_enable_i,
        input  wfi_i,
        input  irq_pending_i,
        input  debug_req_i,
        input  debug_mode_i,
        input  if_busy_i,
        input  lsu_busy_i,
        output ctrl_busy_o,
        output wake_from_sleep_o,
        output halt_if_o,
        output wfi_done_o,
        output timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/cve2_sleep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cve2_sleep_ctrl : WFI sequencing FSM (RUN/DRAIN/SLEEP/WAKE).             |
// | Optional forced wake after WfiTimeout cycles: define CVE2_WFI_TIMEOUT_EN |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cve2_sleep_ctrl
    import cve2_pkg::*;
#(
    parameter int unsigned WakeLatency = 2,
    parameter int unsigned WfiTimeout  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    cve2_sleep_ctrl_if.slave  bus
);

    localparam logic [c_wake_cnt_w-1:0] c_wake_load = c_wake_cnt_w'(WakeLatency - 1);

    sleep_ctrl_state_e         r_state;
    sleep_ctrl_state_e         w_state_next;
    logic [c_wake_cnt_w-1:0]   r_wake_cnt;
    logic [c_wake_cnt_w-1:0]   w_wake_cnt_next;

    logic w_wake_evt;
    logic w_wfi_req;
    logic w_timeout_hit;
    logic w_ctrl_busy;
    logic w_halt_if;
    logic w_wake_from_sleep;
    logic w_wfi_done;
    logic w_timeout;

    assign w_wake_evt = wake_event(bus.irq_pending_i, bus.debug_req_i);
    assign w_wfi_req  = bus.wfi_i & bus.fetch_enable_i;

`ifdef CVE2_WFI_TIMEOUT_EN
    localparam logic [c_timeout_cnt_w-1:0] c_timeout_last = c_timeout_cnt_w'(WfiTimeout - 1);

    logic [c_timeout_cnt_w-1:0] r_sleep_cnt;

    // Zero outside SLEEP, so every SLEEP entry starts counting from 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sleep_cnt <= '0;
        end else if (r_state == SLEEP) begin
            r_sleep_cnt <= r_sleep_cnt + c_timeout_cnt_w'(1);
        end else begin
            r_sleep_cnt <= '0;
        end
    end

    assign w_timeout_hit = (r_state == SLEEP) && (r_sleep_cnt == c_timeout_last);
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (WfiTimeout != 0);
    assign w_timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= RUN;
            r_wake_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wake_cnt <= w_wake_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_wake_cnt_next   = r_wake_cnt;
        w_ctrl_busy       = 1'b1;
        w_halt_if         = 1'b0;
        w_wake_from_sleep = 1'b0;
        w_wfi_done        = 1'b0;
        w_timeout         = 1'b0;

        case (r_state)
            RUN: begin
                if (w_wfi_req) begin
                    // A WFI that could not sleep anyway retires immediately as a NOP.
                    if (bus.debug_mode_i || w_wake_evt) begin
                        w_wfi_done = 1'b1;
                    end else begin
                        w_state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                w_halt_if = 1'b1;
                if (w_wake_evt) begin
                    w_state_next    = WAKE;
                    w_wake_cnt_next = c_wake_load;
                end else if (!bus.if_busy_i && !bus.lsu_busy_i) begin
                    w_state_next = SLEEP;
                end
            end

            SLEEP: begin
                w_ctrl_busy       = 1'b0;
                w_halt_if         = 1'b1;
                w_wake_from_sleep = w_wake_evt;
                if (w_wake_evt) begin
                    w_state_next    = WAKE;
                    w_wake_cnt_next = c_wake_load;
                end else if (w_timeout_hit) begin
                    w_state_next      = WAKE;
                    w_wake_cnt_next   = c_wake_load;
                    w_wake_from_sleep = 1'b1;
                    w_timeout         = 1'b1;
                end
            end

            WAKE: begin
                // Busy stays high here to bridge the sleep unit's registered busy latency.
                w_halt_if         = 1'b1;
                w_wake_from_sleep = 1'b1;
                if (r_wake_cnt == '0) begin
                    w_state_next = RUN;
                    w_wfi_done   = 1'b1;
                end else begin
                    w_wake_cnt_next = r_wake_cnt - c_wake_cnt_w'(1);
                end
            end

            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign bus.ctrl_busy_o       = w_ctrl_busy;
    assign bus.halt_if_o         = w_halt_if;
    assign bus.wake_from_sleep_o = w_wake_from_sleep;
    assign bus.wfi_done_o        = w_wfi_done & rst_ni;
    assign bus.timeout_o         = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cve2_sleep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cve2_sleep_ctrl : directed scoreboard bench for cve2_sleep_ctrl.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_cve2_sleep_ctrl;

    // Input vector order : {fetch_enable, wfi, irq, debug_req, debug_mode, if_busy, lsu_busy}
    // Output vector order: {ctrl_busy, halt_if, wake_from_sleep, wfi_done, timeout}
    localparam logic [4:0] O_RUN      = 5'b10000;
    localparam logic [4:0] O_RUN_DONE = 5'b10010;
    localparam logic [4:0] O_DRAIN    = 5'b11000;
    localparam logic [4:0] O_SLEEP    = 5'b01000;
    localparam logic [4:0] O_SLEEP_WK = 5'b01100;
    localparam logic [4:0] O_WAKE     = 5'b11100;
    localparam logic [4:0] O_WAKE_END = 5'b11110;
    localparam logic [4:0] O_TIMEOUT  = 5'b01101;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    cve2_sleep_ctrl_if bus ();

    cve2_sleep_ctrl #(
        .WakeLatency (2),
        .WfiTimeout  (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_out();
        logic [4:0] obs;
        logic [4:0] exp;
        string      tag;
        obs = {bus.ctrl_busy_o, bus.halt_if_o, bus.wake_from_sleep_o,
               bus.wfi_done_o, bus.timeout_o};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%b expected=<entry>", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    // Drive one cycle of inputs, book the expected outputs, check mid-cycle.
    task automatic step(input string tag, input logic [6:0] in, input logic [4:0] exp);
        {bus.fetch_enable_i, bus.wfi_i, bus.irq_pending_i, bus.debug_req_i,
         bus.debug_mode_i, bus.if_busy_i, bus.lsu_busy_i} = in;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;

        step("reset_0", 7'b0000000, O_RUN);
        step("reset_1", 7'b1000000, O_RUN);
        rst_n = 1'b1;
        step("idle", 7'b1000000, O_RUN);

        // WFI with fetch busy for three DRAIN cycles, irq at SLEEP cycle 5
        step("a_wfi",    7'b1100010, O_RUN);
        step("a_drain1", 7'b1000010, O_DRAIN);
        step("a_drain2", 7'b1000010, O_DRAIN);
        step("a_drain3", 7'b1000000, O_DRAIN);
        for (int i = 1; i <= 4; i++) step($sformatf("a_sleep%0d", i), 7'b1000000, O_SLEEP);
        step("a_sleep5_irq", 7'b1010000, O_SLEEP_WK);
        step("a_wake1",  7'b1000000, O_WAKE);
        step("a_wake2",  7'b1000000, O_WAKE_END);
        step("a_run",    7'b1000000, O_RUN);

        // WFI as NOP when a wake condition is already present
        step("b_irq_nop",   7'b1110000, O_RUN_DONE);
        step("b_after",     7'b1000000, O_RUN);
        step("b_dmode_nop", 7'b1100100, O_RUN_DONE);
        step("b_dreq_nop",  7'b1101000, O_RUN_DONE);
        step("b_after2",    7'b1000000, O_RUN);

        // LSU busy, debug request in DRAIN cycle 2 aborts to WAKE
        step("c_wfi",      7'b1100001, O_RUN);
        step("c_drain1",   7'b1000001, O_DRAIN);
        step("c_drain2",   7'b1001001, O_DRAIN);
        step("c_wake1",    7'b1000000, O_WAKE);
        step("c_wake2",    7'b1000000, O_WAKE_END);
        step("c_run",      7'b1000000, O_RUN);

        // irq in an otherwise idle DRAIN wins over the move to SLEEP
        step("d_wfi",      7'b1100000, O_RUN);
        step("d_drain",    7'b1010000, O_DRAIN);
        step("d_wake1",    7'b1000000, O_WAKE);
        step("d_wake2",    7'b1000000, O_WAKE_END);
        step("d_run",      7'b1000000, O_RUN);

        // WFI ignored while fetch is disabled
        step("e_wfi_nofe", 7'b0100000, O_RUN);
        step("e_after",    7'b0000000, O_RUN);
        step("e_after2",   7'b1000000, O_RUN);

        // Long sleep with no wake event
        step("f_wfi",   7'b1100000, O_RUN);
        step("f_drain", 7'b1000000, O_DRAIN);
        for (int i = 1; i <= 7; i++) step($sformatf("f_sleep%0d", i), 7'b1000000, O_SLEEP);
`ifdef CVE2_WFI_TIMEOUT_EN
        step("f_timeout", 7'b1000000, O_TIMEOUT);
        step("f_wake1",   7'b1000000, O_WAKE);
        step("f_wake2",   7'b1000000, O_WAKE_END);
        step("f_run",     7'b1000000, O_RUN);

        // Real wake coinciding with the timeout cycle: no timeout pulse
        step("g_wfi",   7'b1100000, O_RUN);
        step("g_drain", 7'b1000000, O_DRAIN);
        for (int i = 1; i <= 7; i++) step($sformatf("g_sleep%0d", i), 7'b1000000, O_SLEEP);
        step("g_sleep8_irq", 7'b1010000, O_SLEEP_WK);
        step("g_wake1",      7'b1000000, O_WAKE);
        step("g_wake2",      7'b1000000, O_WAKE_END);
        step("g_run",        7'b1000000, O_RUN);
`else
        step("f_sleep8",  7'b1000000, O_SLEEP);
        step("f_sleep9",  7'b1000000, O_SLEEP);
        step("f_sleep10", 7'b1000000, O_SLEEP);
        step("f_irq",     7'b1010000, O_SLEEP_WK);
        step("f_wake1",   7'b1000000, O_WAKE);
        step("f_wake2",   7'b1000000, O_WAKE_END);
        step("f_run",     7'b1000000, O_RUN);
`endif

        // Reset during SLEEP returns to RUN with no retire pulse
        step("h_wfi",    7'b1100000, O_RUN);
        step("h_drain",  7'b1000000, O_DRAIN);
        step("h_sleep1", 7'b1000000, O_SLEEP);
        rst_n = 1'b0;
        step("h_in_reset", 7'b1000000, O_RUN);
        rst_n = 1'b1;
        step("h_post1", 7'b1000000, O_RUN);
        step("h_post2", 7'b1000000, O_RUN);
        step("h_post3", 7'b1000000, O_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
